// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the ROM address, absorbs the
// ROM's one-cycle read latency and hands {instr, pc} pairs to decode.
module fetch_unit #(
  parameter int unsigned          ADDR_WIDTH = 10,
  parameter int unsigned          DATA_WIDTH = 32,
  parameter int unsigned          PC_WIDTH   = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_rdata,
  input  logic                  rom_rdata_valid,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [PC_WIDTH-1:0]   out_pc
);

  logic [PC_WIDTH-1:0]   pc_q;
  logic [PC_WIDTH-1:0]   inflight_pc_q;
  logic                  inflight_q;
  logic [1:0]            count_q;
  logic [DATA_WIDTH-1:0] head_instr_q, tail_instr_q;
  logic [PC_WIDTH-1:0]   head_pc_q, tail_pc_q;

  logic pop, push, stall, issue;

  assign rom_addr  = pc_q[ADDR_WIDTH+1:2];
  assign out_valid = (count_q != 2'd0);
  assign out_instr = head_instr_q;
  assign out_pc    = head_pc_q;

  // Only issue when the FIFO is guaranteed to have room for the returning word.
  always_comb begin
    pop   = out_valid & out_ready;
    push  = inflight_q & rom_rdata_valid & ~redirect_valid;
    stall = inflight_q & ~rom_rdata_valid;
    issue = ~redirect_valid & ~stall &
            (({1'b0, count_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      count_q       <= 2'd0;
      head_instr_q  <= '0;
      head_pc_q     <= '0;
      tail_instr_q  <= '0;
      tail_pc_q     <= '0;
    end else if (redirect_valid) begin
      pc_q       <= redirect_pc & ~PC_WIDTH'(3);
      inflight_q <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      // A word the ROM could not deliver is re-requested from its own PC.
      if (stall) begin
        pc_q       <= inflight_pc_q;
        inflight_q <= 1'b0;
      end else if (issue) begin
        inflight_q    <= 1'b1;
        inflight_pc_q <= pc_q;
        pc_q          <= pc_q + PC_WIDTH'(4);
      end else begin
        inflight_q <= 1'b0;
      end

      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            head_instr_q <= rom_rdata;
            head_pc_q    <= inflight_pc_q;
          end else begin
            tail_instr_q <= rom_rdata;
            tail_pc_q    <= inflight_pc_q;
          end
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          head_instr_q <= tail_instr_q;
          head_pc_q    <= tail_pc_q;
          count_q      <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            head_instr_q <= rom_rdata;
            head_pc_q    <= inflight_pc_q;
          end else begin
            head_instr_q <= tail_instr_q;
            head_pc_q    <= tail_pc_q;
            tail_instr_q <= rom_rdata;
            tail_pc_q    <= inflight_pc_q;
          end
        end
        default: ;
      endcase
    end
  end

  // The issue rule reserves space, so a push can never meet a full FIFO.
  assert property (@(posedge clk) disable iff (!reset_n)
                   !(push && !pop && count_q == 2'd2));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a registered-read ROM model
// whose word i holds 32'h1000_0000 + i.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  rom_addr;
  logic [31:0] rom_rdata = '0;
  logic        rom_rdata_valid;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  int          compared   = 0;
  int          mismatched = 0;
  int          got;
  logic [31:0] exp_pc;

  fetch_unit dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .rom_addr       (rom_addr),
    .rom_rdata      (rom_rdata),
    .rom_rdata_valid(rom_rdata_valid),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_rdata <= 32'h1000_0000 + {22'd0, rom_addr};

  function automatic logic [31:0] exp_instr(input logic [31:0] pc);
    return 32'h1000_0000 + {22'd0, pc[11:2]};
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Strict stream: a new head must be present every cycle with out_ready=1.
  task automatic expect_stream(input int n);
    for (int i = 0; i < n; i++) begin
      check_output("stream_valid", {31'd0, out_valid}, 32'd1);
      check_output("stream_pc", out_pc, exp_pc);
      check_output("stream_instr", out_instr, exp_instr(exp_pc));
      exp_pc += 32'd4;
      step();
    end
  endtask

  // Gaps allowed, but every delivered entry must be the next PC in order.
  task automatic loose_stream(input int n);
    for (int i = 0; i < n; i++) begin
      if (out_valid) begin
        check_output("loose_pc", out_pc, exp_pc);
        check_output("loose_instr", out_instr, exp_instr(exp_pc));
        exp_pc += 32'd4;
        got++;
      end
      step();
    end
  endtask

  initial begin
    reset_n         = 1'b0;
    rom_rdata_valid = 1'b1;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    out_ready       = 1'b1;
    step();
    step();
    check_output("rst_valid", {31'd0, out_valid}, 32'd0);
    check_output("rst_instr", out_instr, 32'd0);
    check_output("rst_pc", out_pc, 32'd0);
    check_output("rst_addr", {22'd0, rom_addr}, 32'd0);

    reset_n = 1'b1;
    step();
    check_output("lat_c1_valid", {31'd0, out_valid}, 32'd0);
    step();
    exp_pc = 32'd0;
    expect_stream(8);

    // Back-pressure: head 32 held, 36 buffered, nothing in flight, PC 40 parked.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_output("bp_valid", {31'd0, out_valid}, 32'd1);
      check_output("bp_pc", out_pc, 32'd32);
      check_output("bp_instr", out_instr, 32'h1000_0008);
      check_output("bp_addr", {22'd0, rom_addr}, 32'd10);
    end
    out_ready = 1'b1;
    expect_stream(6);

    // ROM not ready for two cycles: one valid, two empty, then seven more.
    got = 0;
    rom_rdata_valid = 1'b0;
    loose_stream(1);
    loose_stream(1);
    rom_rdata_valid = 1'b1;
    loose_stream(8);
    check_output("stall_count", got, 32'd8);
    check_output("stall_next", exp_pc, 32'd88);

    // Redirect with decode stalled and a request in flight.
    out_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    step();
    redirect_valid = 1'b0;
    check_output("rd1_t1_valid", {31'd0, out_valid}, 32'd0);
    step();
    check_output("rd1_t2_valid", {31'd0, out_valid}, 32'd0);
    check_output("rd1_t2_addr", {22'd0, rom_addr}, 32'h41);
    step();
    check_output("rd1_t3_valid", {31'd0, out_valid}, 32'd1);
    check_output("rd1_t3_pc", out_pc, 32'h100);
    check_output("rd1_t3_instr", out_instr, 32'h1000_0040);
    step();
    check_output("rd1_hold_pc", out_pc, 32'h100);
    out_ready = 1'b1;
    exp_pc = 32'h100;
    expect_stream(4);

    // Redirect coinciding with a pop, then again the very next cycle.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    step();
    check_output("rd2_a_valid", {31'd0, out_valid}, 32'd0);
    redirect_pc = 32'h0000_0300;
    step();
    check_output("rd2_b_valid", {31'd0, out_valid}, 32'd0);
    redirect_valid = 1'b0;
    step();
    check_output("rd2_c_valid", {31'd0, out_valid}, 32'd0);
    step();
    exp_pc = 32'h300;
    expect_stream(3);

    // ROM address wraps at 1024 words while out_pc keeps counting.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0FF8;
    step();
    redirect_valid = 1'b0;
    check_output("wrap_a_valid", {31'd0, out_valid}, 32'd0);
    step();
    check_output("wrap_addr_1023", {22'd0, rom_addr}, 32'd1023);
    step();
    check_output("wrap_addr_0", {22'd0, rom_addr}, 32'd0);
    exp_pc = 32'h0000_0FF8;
    expect_stream(4);

    // Full 32-bit PC wrap.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF9;
    step();
    redirect_valid = 1'b0;
    step();
    step();
    exp_pc = 32'hFFFF_FFF8;
    expect_stream(4);

    // Asynchronous reset between clock edges.
    #2;
    reset_n = 1'b0;
    #1;
    check_output("arst_valid", {31'd0, out_valid}, 32'd0);
    check_output("arst_pc", out_pc, 32'd0);
    check_output("arst_addr", {22'd0, rom_addr}, 32'd0);
    step();
    reset_n = 1'b1;
    step();
    check_output("arst_c1_valid", {31'd0, out_valid}, 32'd0);
    step();
    exp_pc = 32'd0;
    expect_stream(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
